// File: rtl/dual_array_writer.sv
`default_nettype none
// ============================================================================
// dual_array_writer: queues index/data update requests and drains up to two
// per cycle onto a 16-entry dual-write-port array; clear zeroes the array.
// Revision 1.0
// ============================================================================
module dual_array_writer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_index,
   input  logic [WIDTH-1:0] req_data,
   input  logic             clear,
   output logic             busy,
   output logic             write_a,
   output logic             write_b,
   output logic [3:0]       index_a,
   output logic [3:0]       index_b,
   output logic [WIDTH-1:0] datain_a,
   output logic [WIDTH-1:0] datain_b
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [2:0]       k_q, k_d;
   logic [3:0]       idx_mem_q [DEPTH];
   logic [3:0]       idx_mem_d [DEPTH];
   logic [WIDTH-1:0] dat_mem_q [DEPTH];
   logic [WIDTH-1:0] dat_mem_d [DEPTH];

   logic [PTR_W-1:0] rd_ptr_nx;
   logic             push;
   logic [1:0]       n_pop;

   assign rd_ptr_nx = rd_ptr_q + PTR_W'(1);

   always_comb begin
      state_d   = state_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      k_d       = k_q;
      idx_mem_d = idx_mem_q;
      dat_mem_d = dat_mem_q;
      n_pop     = 2'd0;
      write_a   = 1'b0;
      write_b   = 1'b0;
      index_a   = 4'd0;
      index_b   = 4'd0;
      datain_a  = '0;
      datain_b  = '0;
      busy      = (state_q == CLEAR);
      req_ready = (state_q == RUN) && (count_q < CNT_W'(DEPTH)) && !clear;
      push      = req_valid && req_ready;

      case (state_q)
         RUN: begin
            if (clear) begin
               // Flush: the read pointer jumps to the write pointer.
               state_d  = CLEAR;
               k_d      = 3'd0;
               rd_ptr_d = wr_ptr_q;
               count_d  = '0;
            end else begin
               if (count_q >= CNT_W'(2)) begin
                  n_pop = 2'd2;
                  if (idx_mem_q[rd_ptr_nx] == idx_mem_q[rd_ptr_q]) begin
                     // Same target: only the younger entry matters.
                     write_a  = 1'b1;
                     index_a  = idx_mem_q[rd_ptr_nx];
                     datain_a = dat_mem_q[rd_ptr_nx];
                  end else begin
                     write_a  = 1'b1;
                     index_a  = idx_mem_q[rd_ptr_q];
                     datain_a = dat_mem_q[rd_ptr_q];
                     write_b  = 1'b1;
                     index_b  = idx_mem_q[rd_ptr_nx];
                     datain_b = dat_mem_q[rd_ptr_nx];
                  end
               end else if (count_q == CNT_W'(1)) begin
                  n_pop    = 2'd1;
                  write_a  = 1'b1;
                  index_a  = idx_mem_q[rd_ptr_q];
                  datain_a = dat_mem_q[rd_ptr_q];
               end
               rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
               if (push) begin
                  idx_mem_d[wr_ptr_q] = req_index;
                  dat_mem_d[wr_ptr_q] = req_data;
                  wr_ptr_d            = wr_ptr_q + PTR_W'(1);
               end
               count_d = count_q + CNT_W'(push) - CNT_W'(n_pop);
            end
         end
         CLEAR: begin
            write_a = 1'b1;
            index_a = {k_q, 1'b0};
            write_b = 1'b1;
            index_b = {k_q, 1'b1};
            k_d     = k_q + 3'd1;
            if (k_q == 3'd7) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         k_q      <= 3'd0;
         for (int i = 0; i < DEPTH; i++) begin
            idx_mem_q[i] <= 4'd0;
            dat_mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         k_q       <= k_d;
         idx_mem_q <= idx_mem_d;
         dat_mem_q <= dat_mem_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dual_array_writer.sv
`default_nettype none
// ============================================================================
// tb_dual_array_writer: queue-based reference model feeding a scoreboard that
// a negedge monitor drains against the array write ports.
// Revision 1.0
// ============================================================================
module tb_dual_array_writer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_index;
   logic [WIDTH-1:0] req_data;
   logic             clear;
   logic             busy;
   logic             write_a, write_b;
   logic [3:0]       index_a, index_b;
   logic [WIDTH-1:0] datain_a, datain_b;

   always #5 clk = ~clk;

   dual_array_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_index (req_index),
      .req_data  (req_data),
      .clear     (clear),
      .busy      (busy),
      .write_a   (write_a),
      .write_b   (write_b),
      .index_a   (index_a),
      .index_b   (index_b),
      .datain_a  (datain_a),
      .datain_b  (datain_b)
   );

   typedef struct {
      logic [3:0]       idx;
      logic [WIDTH-1:0] data;
   } req_t;

   typedef struct {
      logic             wa;
      logic [3:0]       ia;
      logic [WIDTH-1:0] da;
      logic             wb;
      logic [3:0]       ib;
      logic [WIDTH-1:0] db;
   } wr_t;

   req_t pend[$];
   wr_t  exp_q[$];
   bit   m_clear;
   int   m_k;
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock cycle of stimulus; the model decides this cycle's writes from
   // the pending list as it stood before the edge, then applies the edge.
   task automatic step(input bit v, input logic [3:0] idx, input logic [WIDTH-1:0] data, input bit clr);
      wr_t e;
      bit  have;
      bit  exp_ready;
      bit  exp_busy;
      @(negedge clk);
      req_valid = v;
      req_index = idx;
      req_data  = data;
      clear     = clr;
      #1;
      e        = '{wa: 1'b0, ia: 4'd0, da: '0, wb: 1'b0, ib: 4'd0, db: '0};
      have     = 1'b0;
      exp_busy = m_clear;
      if (m_clear) begin
         exp_ready = 1'b0;
         e.wa = 1'b1; e.ia = 4'(2 * m_k);
         e.wb = 1'b1; e.ib = 4'(2 * m_k + 1);
         have = 1'b1;
         m_k++;
         if (m_k == 8) m_clear = 1'b0;
      end else begin
         exp_ready = (pend.size() < DEPTH) && !clr;
         if (clr) begin
            pend.delete();
            m_clear = 1'b1;
            m_k     = 0;
         end else if (pend.size() >= 2) begin
            have = 1'b1;
            if (pend[0].idx == pend[1].idx) begin
               e.wa = 1'b1; e.ia = pend[1].idx; e.da = pend[1].data;
            end else begin
               e.wa = 1'b1; e.ia = pend[0].idx; e.da = pend[0].data;
               e.wb = 1'b1; e.ib = pend[1].idx; e.db = pend[1].data;
            end
            void'(pend.pop_front());
            void'(pend.pop_front());
         end else if (pend.size() == 1) begin
            have = 1'b1;
            e.wa = 1'b1; e.ia = pend[0].idx; e.da = pend[0].data;
            void'(pend.pop_front());
         end
         if (v && exp_ready) pend.push_back('{idx: idx, data: data});
      end
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("busy", 64'(busy), 64'(exp_busy));
      if (have) exp_q.push_back(e);
   endtask

   always begin
      @(negedge clk);
      #2;
      if (write_a || write_b) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got wa=%0b ia=%0d wb=%0b ib=%0d expected none at %0t",
                     write_a, index_a, write_b, index_b, $time);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_a", 64'(write_a), 64'(e.wa));
            check("index_a", 64'(index_a), 64'(e.ia));
            check("datain_a", 64'(datain_a), 64'(e.da));
            check("write_b", 64'(write_b), 64'(e.wb));
            check("index_b", 64'(index_b), 64'(e.ib));
            check("datain_b", 64'(datain_b), 64'(e.db));
            if (write_a && write_b) check("distinct_idx", 64'(index_a == index_b), 64'(0));
         end
      end else begin
         if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL missing_write: got none expected ia=%0d ib=%0d at %0t",
                     exp_q[0].ia, exp_q[0].ib, $time);
            void'(exp_q.pop_front());
         end
         check("idle_ports", {24'd0, index_a, index_b, datain_a}, 64'd0);
         check("idle_datain_b", 64'(datain_b), 64'd0);
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, '0, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_index = 4'd0;
      req_data  = '0;
      clear     = 1'b0;
      m_clear   = 1'b0;
      m_k       = 0;
      #1;
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_writes", {62'd0, write_a, write_b}, 64'd0);
      check("rst_ports", {24'd0, index_a, index_b, datain_a}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single request.
      step(1'b1, 4'd3, 32'hA5, 1'b0);
      idle(3);

      // Burst of requests with valid held high.
      step(1'b1, 4'd1, 32'h11, 1'b0);
      step(1'b1, 4'd2, 32'h22, 1'b0);
      step(1'b1, 4'd3, 32'h33, 1'b0);
      step(1'b1, 4'd4, 32'h44, 1'b0);
      step(1'b1, 4'd9, 32'h55, 1'b0);
      idle(2);

      // Back-to-back to the same index.
      step(1'b1, 4'd5, 32'h1, 1'b0);
      step(1'b1, 4'd5, 32'h2, 1'b0);
      idle(2);

      // Clear with traffic behind it, then the full sweep and recovery.
      step(1'b1, 4'd6, 32'h66, 1'b0);
      step(1'b1, 4'd7, 32'h77, 1'b0);
      step(1'b0, 4'd0, '0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 4'd8, 32'hDEAD, (i == 2));
      step(1'b1, 4'd8, 32'hBEEF, 1'b0);
      idle(2);

      // Request and clear together: request refused, clear wins.
      step(1'b1, 4'd7, 32'h1234, 1'b1);
      idle(10);

      // Reset in the k=3 clear cycle.
      step(1'b0, 4'd0, '0, 1'b1);
      idle(3);
      @(negedge clk);
      check("pre_rst_busy", 64'(busy), 64'd1);
      check("pre_rst_index_a", 64'(index_a), 64'd6);
      rst_n = 1'b0;
      #1;
      check("async_rst_writes", {62'd0, write_a, write_b}, 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_ports", {24'd0, index_a, index_b, datain_a}, 64'd0);
      check("async_rst_ready", 64'(req_ready), 64'd1);
      pend.delete();
      exp_q.delete();
      m_clear = 1'b0;
      m_k     = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      step(1'b1, 4'd12, 32'hC0DE, 1'b0);
      idle(2);

      // Randomized traffic; narrow index range makes repeats likely.
      for (int i = 0; i < 400; i++) begin
         bit               v;
         bit               c;
         logic [3:0]       ix;
         logic [WIDTH-1:0] d;
         v  = ($urandom_range(0, 99) < 70);
         c  = ($urandom_range(0, 99) < 3);
         ix = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         d  = $urandom;
         step(v, ix, d, c);
      end
      idle(12);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
